// File: rtl/hlsm_pkg.sv
// Shared definitions for the HLSM family: state encoding and elaboration-time
// parameter checks reused by sibling blocks.
package hlsm_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADD  = 3'd1,
    S_CMP  = 3'd2,
    S_SEL  = 3'd3,
    S_SHF  = 3'd4
  } state_t;

  // True when a shift distance is usable on a word of the given width.
  function automatic bit shift_ok(input int step, input int width);
    return (step >= 0) && (step < width);
  endfunction

endpackage

// File: rtl/hlsm_cmp.sv
// Combinational equality / less-than unit; signedness of lt fixed at elaboration.
module hlsm_cmp #(
  parameter int DATA_W     = 32,
  parameter int SIGNED_CMP = 0
) (
  input  logic [DATA_W-1:0] d,
  input  logic [DATA_W-1:0] e,
  output logic              eq,
  output logic              lt
);

  assign eq = (d == e);

  if (SIGNED_CMP != 0) begin : g_signed
    assign lt = ($signed(d) < $signed(e));
  end else begin : g_unsigned
    assign lt = (d < e);
  end

endmodule

// File: rtl/hlsm_param_seq.sv
// Five-cycle Start/Done compute leaf: d=a+b, e=a+c compared, then x/z selected
// and shifted from latched operands; results held until the next job completes.
module hlsm_param_seq
  import hlsm_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SIGNED_CMP = 0,
  parameter int SHIFT_STEP = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  input  logic [DATA_W-1:0] seven,
  input  logic [DATA_W-1:0] nine,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] z,
  output logic [DATA_W-1:0] f
);

  if (!shift_ok(SHIFT_STEP, DATA_W)) begin : g_bad_shift
    $error("hlsm_param_seq: SHIFT_STEP must lie in 0..DATA_W-1");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [DATA_W-1:0] seven_q, seven_d, nine_q, nine_d;
  logic [DATA_W-1:0] d_q, d_d, e_q, e_d, fr_q, fr_d;
  logic [DATA_W-1:0] hreg_q, hreg_d, greg_q, greg_d;
  logic [DATA_W-1:0] x_q, x_d, z_q, z_d, f_q, f_d;
  logic              eq_q, eq_d, lt_q, lt_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              eq_w, lt_w;

  hlsm_cmp #(.DATA_W(DATA_W), .SIGNED_CMP(SIGNED_CMP)) u_cmp (
    .d (d_q),
    .e (e_q),
    .eq(eq_w),
    .lt(lt_w)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;     b_d    = b_q;    c_d    = c_q;
    seven_d = seven_q; nine_d = nine_q;
    d_d     = d_q;     e_d    = e_q;    fr_d   = fr_q;
    eq_d    = eq_q;    lt_d   = lt_q;
    hreg_d  = hreg_q;  greg_d = greg_q;
    x_d     = x_q;     z_d    = z_q;    f_d    = f_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (Start) begin
          a_d     = a;     b_d    = b;    c_d = c;
          seven_d = seven; nine_d = nine;
          busy_d  = 1'b1;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        d_d     = a_q + b_q;
        e_d     = a_q + c_q;
        fr_d    = a_q - b_q;
        state_d = S_CMP;
      end
      S_CMP: begin
        eq_d    = eq_w;
        lt_d    = lt_w;
        state_d = S_SEL;
      end
      S_SEL: begin
        hreg_d  = eq_q ? (nine_q + a_q) : nine_q;
        greg_d  = seven_q;
        state_d = S_SHF;
      end
      S_SHF: begin
        x_d     = lt_q ? (hreg_q << SHIFT_STEP) : hreg_q;
        z_d     = eq_q ? (greg_q >> SHIFT_STEP) : greg_q;
        f_d     = fr_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      // Unused encodings recover to a quiet IDLE.
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0; b_q    <= '0; c_q    <= '0;
      seven_q <= '0; nine_q <= '0;
      d_q     <= '0; e_q    <= '0; fr_q   <= '0;
      eq_q    <= 1'b0; lt_q <= 1'b0;
      hreg_q  <= '0; greg_q <= '0;
      x_q     <= '0; z_q    <= '0; f_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;     b_q    <= b_d;    c_q    <= c_d;
      seven_q <= seven_d; nine_q <= nine_d;
      d_q     <= d_d;     e_q    <= e_d;    fr_q   <= fr_d;
      eq_q    <= eq_d;    lt_q   <= lt_d;
      hreg_q  <= hreg_d;  greg_q <= greg_d;
      x_q     <= x_d;     z_q    <= z_d;    f_q    <= f_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy = busy_q;
  assign Done = done_q;
  assign x    = x_q;
  assign z    = z_q;
  assign f    = f_q;

endmodule

// File: tb/tb_hlsm_param_seq.sv
// Randomized bench for hlsm_param_seq: unsigned- and signed-compare instances
// share stimulus and are checked against an arithmetic reference model.
module tb_hlsm_param_seq;

  localparam int DW = 32;
  localparam int SH = 1;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Start;
  logic [DW-1:0] a, b, c, seven, nine;
  logic          Busy_u, Done_u, Busy_s, Done_s;
  logic [DW-1:0] x_u, z_u, f_u, x_s, z_s, f_s;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] hold_x, hold_z;

  always #5 Clk = ~Clk;

  hlsm_param_seq #(.DATA_W(DW), .SIGNED_CMP(0), .SHIFT_STEP(SH)) dut_u (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .a(a), .b(b), .c(c), .seven(seven), .nine(nine),
    .Busy(Busy_u), .Done(Done_u), .x(x_u), .z(z_u), .f(f_u)
  );

  hlsm_param_seq #(.DATA_W(DW), .SIGNED_CMP(1), .SHIFT_STEP(SH)) dut_s (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start),
    .a(a), .b(b), .c(c), .seven(seven), .nine(nine),
    .Busy(Busy_s), .Done(Done_s), .x(x_s), .z(z_s), .f(f_s)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: the job's result from plain arithmetic on the latched operands.
  function automatic void model(input logic [DW-1:0] ma, mb, mc, ms, mn, input bit sg,
                                output logic [DW-1:0] mx, mz, mf);
    logic [DW-1:0] dd, ee, h;
    bit eqv, ltv;
    dd  = ma + mb;
    ee  = ma + mc;
    eqv = (dd == ee);
    ltv = sg ? ($signed(dd) < $signed(ee)) : (dd < ee);
    h   = eqv ? mn + ma : mn;
    mx  = ltv ? h << SH : h;
    mz  = eqv ? ms >> SH : ms;
    mf  = ma - mb;
  endfunction

  task automatic drive_ops(input logic [DW-1:0] ia, ib, ic, is, in_);
    a = ia; b = ib; c = ic; seven = is; nine = in_;
  endtask

  task automatic scramble();
    drive_ops($urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // One job from IDLE; optional spurious Start at accept+2; checks latency and results.
  task automatic run_job(input string tag, input logic [DW-1:0] ia, ib, ic, is, in_,
                         input bit poke);
    logic [DW-1:0] ex_u, ez_u, ef_u, ex_s, ez_s, ef_s;
    int cnt;
    model(ia, ib, ic, is, in_, 1'b0, ex_u, ez_u, ef_u);
    model(ia, ib, ic, is, in_, 1'b1, ex_s, ez_s, ef_s);
    @(negedge Clk);
    drive_ops(ia, ib, ic, is, in_);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    scramble();
    check({tag, "_busy"}, {31'b0, Busy_u}, 32'd1);
    cnt = 1;
    while (!Done_u && cnt < 10) begin
      check({tag, "_xhold"}, x_u, hold_x);
      check({tag, "_zhold"}, z_u, hold_z);
      @(negedge Clk);
      cnt++;
      if (poke && cnt == 2) begin Start = 1'b1; scramble(); end
      else Start = 1'b0;
    end
    Start = 1'b0;
    check({tag, "_lat"}, cnt, 32'd5);
    check({tag, "_done_s"}, {31'b0, Done_s}, 32'd1);
    check({tag, "_busy_end"}, {31'b0, Busy_u}, 32'd0);
    check({tag, "_x_u"}, x_u, ex_u);
    check({tag, "_z_u"}, z_u, ez_u);
    check({tag, "_f_u"}, f_u, ef_u);
    check({tag, "_x_s"}, x_s, ex_s);
    check({tag, "_z_s"}, z_s, ez_s);
    check({tag, "_f_s"}, f_s, ef_s);
    hold_x = ex_u;
    hold_z = ez_u;
    @(negedge Clk);
    check({tag, "_done_pulse"}, {31'b0, Done_u}, 32'd0);
    check({tag, "_x_held"}, x_u, ex_u);
    if (poke) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge Clk);
        check({tag, "_no_extra_done"}, {31'b0, Done_u}, 32'd0);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] ex, ez, ef;
    int cnt;
    Rst_n = 1'b0;
    Start = 1'b0;
    drive_ops('0, '0, '0, '0, '0);
    hold_x = '0;
    hold_z = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", {31'b0, Busy_u}, 32'd0);
    check("rst_done", {31'b0, Done_u}, 32'd0);
    check("rst_x", x_u, 32'd0);
    check("rst_z", z_u, 32'd0);
    check("rst_f", f_u, 32'd0);
    Rst_n = 1'b1;

    run_job("t1", 32'd5, 32'd3, 32'd3, 32'd7, 32'd9, 1'b0);
    check("t1_x_lit", x_u, 32'd14);
    check("t1_z_lit", z_u, 32'd3);
    run_job("t2", 32'd5, 32'd2, 32'd3, 32'd7, 32'd9, 1'b0);
    check("t2_x_lit", x_u, 32'd18);
    run_job("t3", 32'd0, 32'hFFFFFFFF, 32'd0, 32'd7, 32'd9, 1'b0);
    check("t3_x_unsigned", x_u, 32'd9);
    check("t3_x_signed", x_s, 32'd18);
    check("t3_f", f_s, 32'd1);
    run_job("t4", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd7, 32'd9, 1'b0);
    check("t4_x_lit", x_u, 32'd18);
    check("t4_f_lit", f_u, 32'hFFFFFFFE);

    run_job("t5_ignore", 32'd11, 32'd4, 32'd4, 32'd100, 32'd20, 1'b1);

    // Start held high: second job accepted on the edge that clears Done.
    @(negedge Clk);
    drive_ops(32'd2, 32'd6, 32'd6, 32'd40, 32'd1);
    Start = 1'b1;
    cnt = 0;
    while (!Done_u && cnt < 10) begin @(negedge Clk); cnt++; end
    check("t5_hold_lat1", cnt, 32'd5);
    model(32'd2, 32'd6, 32'd6, 32'd40, 32'd1, 1'b0, ex, ez, ef);
    check("t5_hold_x1", x_u, ex);
    drive_ops(32'd3, 32'd1, 32'd2, 32'd50, 32'd8);
    cnt = 0;
    do begin @(negedge Clk); cnt++; end while (!Done_u && cnt < 10);
    Start = 1'b0;
    check("t5_hold_lat2", cnt, 32'd5);
    model(32'd3, 32'd1, 32'd2, 32'd50, 32'd8, 1'b0, ex, ez, ef);
    check("t5_hold_x2", x_u, ex);
    check("t5_hold_z2", z_u, ez);
    hold_x = ex;
    hold_z = ez;

    // Asynchronous abort mid-job.
    @(negedge Clk);
    drive_ops(32'd9, 32'd9, 32'd9, 32'd9, 32'd9);
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (2) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    check("t6_busy", {31'b0, Busy_u}, 32'd0);
    check("t6_done", {31'b0, Done_u}, 32'd0);
    check("t6_x", x_u, 32'd0);
    check("t6_z", z_u, 32'd0);
    check("t6_f", f_u, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    hold_x = '0;
    hold_z = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("t6_no_done", {31'b0, Done_u}, 32'd0);
    end
    run_job("t6_after", 32'd5, 32'd3, 32'd3, 32'd7, 32'd9, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [DW-1:0] ra, rb, rc;
      ra = $urandom;
      rb = $urandom;
      rc = ($urandom_range(0, 2) == 0) ? rb : $urandom;
      run_job("rnd", ra, rb, rc, $urandom, $urandom, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
